pipe_gen: RTL and testbench
===========================

PIPE_GEN -- requirements
Module: pipe_gen

Interface
REQ-001 The block SHALL be parameterized as follows (one per line: name, default, meaning):
- WIDTH, 10, pipe_x width
- HEIGHT, 10, pipe_y width
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- PIPE_WIDTH, 30, pipe half-width in pixels
- PIPE_HEIGHT, 100, gap half-height in pixels
- SPEED, 2, pixels moved per frame tick
- BIRD_X, 200, fixed bird column
- LFSR_SEED, 10'h1A5, LFSR reset value; nonzero
REQ-002 The block SHALL have these ports (one per line: name, direction, width, meaning):
- clk, in, 1, the single clock
- reset, in, 1, synchronous active-low reset
- frame_tick, in, 1, one-cycle pulse per video frame
- start, in, 1, one-cycle pulse that starts or restarts a game
- collision, in, 1, level from the collision checker
- pipe_x, out, WIDTH, pipe centre column
- pipe_y, out, HEIGHT, gap centre row
- pipe_passed, out, 1, one-cycle pulse when the pipe passes the bird
- score, out, 8, pipes passed in this game
- game_over, out, 1, high while in the DEAD state
REQ-003 There SHALL be one clock (clk); reset SHALL be synchronous and active-low, sampled only on the rising edge of clk.
REQ-004 Constraints: SPAWN_X = SCREEN_W + PIPE_WIDTH SHALL be less than 2^WIDTH; PIPE_HEIGHT + 255 SHALL be at most SCREEN_H - PIPE_HEIGHT.

Function
REQ-005 The FSM SHALL have three states: IDLE, RUN and DEAD.
REQ-006 In IDLE, outputs SHALL hold pipe_x=SPAWN_X, pipe_y=SCREEN_H/2, score=0; start SHALL move the FSM to RUN on the next edge.
REQ-007 In RUN, a frame_tick with collision=0 SHALL update pipe_x once. If pipe_x >= PIPE_WIDTH+SPEED, then pipe_x := pipe_x-SPEED; otherwise the pipe respawns.
REQ-008 On respawn, pipe_x SHALL load SPAWN_X and pipe_y SHALL load PIPE_HEIGHT + lfsr[7:0], using the LFSR value present in that cycle.
REQ-009 The LFSR SHALL be 10-bit Fibonacci, polynomial x^10+x^7+1, and SHALL advance every clock in every state; it SHALL never reach zero.
REQ-010 Pass detection: in RUN, when a tick moves pipe_x from >= BIRD_X to < BIRD_X, pipe_passed SHALL be 1 for exactly the following cycle and score SHALL increment.
REQ-011 score SHALL saturate at 255; a pass at 255 SHALL still pulse pipe_passed.
REQ-012 A respawn SHALL never generate a pass.
REQ-013 In RUN, collision=1 SHALL move the FSM to DEAD on the next edge. If frame_tick occurs in the same cycle, collision SHALL win: no move and no pass.
REQ-014 In DEAD, pipe_x, pipe_y and score SHALL hold, frame_tick SHALL be ignored, and game_over SHALL be 1.
REQ-015 In DEAD, start SHALL move the FSM to IDLE, loading the IDLE values on the same edge; this is the only exit from DEAD.
REQ-016 start SHALL be ignored in RUN; collision SHALL be ignored in IDLE and DEAD.
REQ-017 All outputs SHALL be registered, with no combinational path from input to output.
REQ-018 Position latency SHALL be exactly one clock from frame_tick to the updated pipe_x.
REQ-019 All position arithmetic SHALL be unsigned WIDTH-bit; the REQ-007 guard SHALL prevent underflow.

Reset
REQ-020 When reset=0 at a clock edge, the block SHALL take these values on that edge, regardless of state:
- state = IDLE
- pipe_x = SPAWN_X (670)
- pipe_y = SCREEN_H/2 (240)
- score = 0
- pipe_passed = 0
- game_over = 0
- lfsr = LFSR_SEED
REQ-021 A reset asserted in the middle of a game SHALL discard any pending pass pulse or pending collision.

Verification
REQ-022 Reset then idle: hold reset=0 for 2 clocks, then release and give 10 ticks with no start. Required: pipe_x=670, pipe_y=240, score=0, game_over=0 throughout.
REQ-023 Scroll and pass: start, then 235 ticks. Required: pipe_x=200, no pulse. The 236th tick SHALL give pipe_x=198, a one-cycle pipe_passed, and score=1.
REQ-024 Respawn: continue to tick 320, where pipe_x=30. Tick 321 SHALL give pipe_x=670, pipe_y equal to 100 + lfsr[7:0] from a reference model, and no pass.
REQ-025 Collision priority: in RUN at pipe_x=400, assert collision and frame_tick in the same cycle. Required: pipe_x stays 400, game_over=1 next cycle, and further ticks have no effect.
REQ-026 Restart: in DEAD with score=3, pulse start. Required: IDLE values next cycle; a second start enters RUN with score=0.
REQ-027 Saturation and mid-game reset: force score to 255 and pass a pipe. Required: score stays 255 and pipe_passed pulses. Then assert reset during RUN; all outputs SHALL take their reset values on that edge.

Source files
------------

// File: rtl/pipe_gen.sv
// pipe_gen -- scrolling pipe generator for a side-scrolling bird game.
//
// Moves one pipe leftwards by SPEED pixels per frame tick. When the pipe
// goes off the left edge, it respawns at the right edge with a
// pseudo-random gap height. The block also counts the pipes that pass
// the bird column and freezes when a collision is reported.
//
// Ports:
//   clk          single clock
//   reset        synchronous, active-low reset
//   frame_tick   one-cycle pulse per video frame
//   start        starts a game from IDLE; returns to IDLE from DEAD
//   collision    level from the collision checker (only used in RUN)
//   pipe_x       pipe centre column
//   pipe_y       gap centre row
//   pipe_passed  one-cycle pulse when the pipe crosses the bird column
//   score        pipes passed in this game, saturating at 255
//   game_over    high while in DEAD
module pipe_gen #(
    parameter int unsigned WIDTH       = 10,
    parameter int unsigned HEIGHT      = 10,
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned PIPE_WIDTH  = 30,
    parameter int unsigned PIPE_HEIGHT = 100,
    parameter int unsigned SPEED       = 2,
    parameter int unsigned BIRD_X      = 200,
    parameter logic [9:0]  LFSR_SEED   = 10'h1A5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic              start,
    input  logic              collision,
    output logic [WIDTH-1:0]  pipe_x,
    output logic [HEIGHT-1:0] pipe_y,
    output logic              pipe_passed,
    output logic [7:0]        score,
    output logic              game_over
);

    localparam logic [WIDTH-1:0]  SPAWN_X = WIDTH'(SCREEN_W + PIPE_WIDTH);
    localparam logic [WIDTH-1:0]  MIN_X   = WIDTH'(PIPE_WIDTH + SPEED);
    localparam logic [WIDTH-1:0]  SPEED_W = WIDTH'(SPEED);
    localparam logic [WIDTH-1:0]  BIRD_XW = WIDTH'(BIRD_X);
    localparam logic [HEIGHT-1:0] MID_Y   = HEIGHT'(SCREEN_H / 2);
    localparam logic [HEIGHT-1:0] GAP_MIN = HEIGHT'(PIPE_HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  pipe_x_q;
    logic [HEIGHT-1:0] pipe_y_q;
    logic [7:0]        score_q;
    logic              passed_q;
    logic              game_over_q;
    logic [9:0]        lfsr_q;

    logic [9:0]        lfsr_d;
    logic [WIDTH-1:0]  x_dec_d;
    logic [HEIGHT-1:0] respawn_y_d;

    // Fibonacci LFSR for x^10 + x^7 + 1: taps on bits 9 and 6.
    always_comb begin
        lfsr_d      = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
        // Only consumed when pipe_x_q >= MIN_X, so this never wraps in use.
        x_dec_d     = pipe_x_q - SPEED_W;
        respawn_y_d = GAP_MIN + HEIGHT'(lfsr_q[7:0]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pipe_x_q    <= SPAWN_X;
            pipe_y_q    <= MID_Y;
            score_q     <= '0;
            passed_q    <= 1'b0;
            game_over_q <= 1'b0;
            lfsr_q      <= LFSR_SEED;
        end else begin
            lfsr_q   <= lfsr_d;
            passed_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Collision outranks a same-cycle tick: nothing moves.
                    if (collision) begin
                        state_q     <= S_DEAD;
                        game_over_q <= 1'b1;
                    end else if (frame_tick) begin
                        if (pipe_x_q >= MIN_X) begin
                            pipe_x_q <= x_dec_d;
                            if ((pipe_x_q >= BIRD_XW) && (x_dec_d < BIRD_XW)) begin
                                passed_q <= 1'b1;
                                if (score_q != '1) begin
                                    score_q <= score_q + 8'd1;
                                end
                            end
                        end else begin
                            pipe_x_q <= SPAWN_X;
                            pipe_y_q <= respawn_y_d;
                        end
                    end
                end
                S_DEAD: begin
                    if (start) begin
                        state_q     <= S_IDLE;
                        pipe_x_q    <= SPAWN_X;
                        pipe_y_q    <= MID_Y;
                        score_q     <= '0;
                        game_over_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pipe_x      = pipe_x_q;
    assign pipe_y      = pipe_y_q;
    assign pipe_passed = passed_q;
    assign score       = score_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_pipe_gen.sv
// Testbench for pipe_gen. Two instances are used: one with the default
// geometry, and one with a narrow screen so that the score can reach
// saturation in a few thousand frames. Both instances are compared every
// cycle against a frame-level behavioural model of the game.
module tb_pipe_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (default parameters)
    logic       rst, ft, st, co;
    logic [9:0] pipe_x, pipe_y;
    logic       pipe_passed, game_over;
    logic [7:0] score;

    // Small-screen instance
    logic       s_rst, s_ft, s_st, s_co;
    logic [9:0] s_x, s_y;
    logic       s_passed, s_over;
    logic [7:0] s_score;

    pipe_gen dut (
        .clk(clk), .reset(rst), .frame_tick(ft), .start(st), .collision(co),
        .pipe_x(pipe_x), .pipe_y(pipe_y), .pipe_passed(pipe_passed),
        .score(score), .game_over(game_over)
    );

    pipe_gen #(.SCREEN_W(64), .PIPE_WIDTH(4), .BIRD_X(20)) dut_s (
        .clk(clk), .reset(s_rst), .frame_tick(s_ft), .start(s_st), .collision(s_co),
        .pipe_x(s_x), .pipe_y(s_y), .pipe_passed(s_passed),
        .score(s_score), .game_over(s_over)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int MODE_IDLE = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_DEAD = 2;

    typedef struct {
        int sw, sh, pw, ph, sp, bx;
    } prm_t;

    typedef struct {
        int       mode;
        int       x, y, score;
        bit       passed, over;
        bit [9:0] lfsr;
    } mdl_t;

    localparam prm_t P1 = '{sw: 640, sh: 480, pw: 30, ph: 100, sp: 2, bx: 200};
    localparam prm_t P2 = '{sw: 64,  sh: 480, pw: 4,  ph: 100, sp: 2, bx: 20};

    mdl_t m, m2;

    function automatic mdl_t step(input mdl_t s, input prm_t p,
                                  input bit r, input bit t, input bit go, input bit c);
        mdl_t n;
        int   nx;
        n = s;
        n.passed = 1'b0;
        // polynomial x^10 + x^7 + 1: feedback from terms 10 and 7
        n.lfsr = {s.lfsr[8:0], s.lfsr[9] ^ s.lfsr[6]};
        if (!r) begin
            n.mode = MODE_IDLE; n.x = p.sw + p.pw; n.y = p.sh / 2;
            n.score = 0; n.over = 1'b0; n.lfsr = 10'h1A5;
            return n;
        end
        case (s.mode)
            MODE_IDLE: if (go) n.mode = MODE_RUN;
            MODE_RUN: begin
                if (c) n.mode = MODE_DEAD;
                else if (t) begin
                    if (s.x >= p.pw + p.sp) begin
                        nx = s.x - p.sp;
                        if (s.x >= p.bx && nx < p.bx) begin
                            n.passed = 1'b1;
                            n.score  = (s.score >= 255) ? 255 : s.score + 1;
                        end
                        n.x = nx;
                    end else begin
                        n.x = p.sw + p.pw;
                        n.y = p.ph + int'(s.lfsr[7:0]);
                    end
                end
            end
            default: if (go) begin
                n.mode = MODE_IDLE; n.x = p.sw + p.pw; n.y = p.sh / 2; n.score = 0;
            end
        endcase
        n.over = (n.mode == MODE_DEAD);
        return n;
    endfunction

    task automatic cycle();
        @(posedge clk);
        m  = step(m,  P1, rst,   ft,   st,   co);
        m2 = step(m2, P2, s_rst, s_ft, s_st, s_co);
        @(negedge clk);
        chk("m_x",      32'(pipe_x),      32'(m.x));
        chk("m_y",      32'(pipe_y),      32'(m.y));
        chk("m_score",  32'(score),       32'(m.score));
        chk("m_passed", 32'(pipe_passed), 32'(m.passed));
        chk("m_over",   32'(game_over),   32'(m.over));
        chk("s_x",      32'(s_x),         32'(m2.x));
        chk("s_y",      32'(s_y),         32'(m2.y));
        chk("s_score",  32'(s_score),     32'(m2.score));
        chk("s_passed", 32'(s_passed),    32'(m2.passed));
        chk("s_over",   32'(s_over),      32'(m2.over));
    endtask

    task automatic drv(input bit r, input bit t, input bit go, input bit c);
        rst = r; ft = t; st = go; co = c;
        cycle();
    endtask

    task automatic drv_s(input bit r, input bit t, input bit go, input bit c);
        s_rst = r; s_ft = t; s_st = go; s_co = c;
        cycle();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_x"},     32'(pipe_x),    32'd670);
        chk({tag, "_y"},     32'(pipe_y),    32'd240);
        chk({tag, "_score"}, 32'(score),     32'd0);
        chk({tag, "_over"},  32'(game_over), 32'd0);
    endtask

    int pulses;
    int guard;
    int exp_y;

    initial begin
        m = '{default: 0}; m2 = '{default: 0};
        s_rst = 1'b0; s_ft = 1'b0; s_st = 1'b0; s_co = 1'b0;

        // Reset, then idle ticks with no start
        drv(0, 0, 0, 0);
        drv(0, 0, 0, 0);
        chk_idle("rst");
        chk("rst_passed", 32'(pipe_passed), 32'd0);
        for (int i = 0; i < 10; i++) begin
            drv(1, 1, 0, $urandom_range(0, 1));
            chk_idle("idle");
        end

        // Scroll to the bird column, then pass it
        drv(1, 0, 1, 0);
        pulses = 0;
        for (int i = 0; i < 235; i++) begin
            drv(1, 1, 0, 0);
            pulses += int'(pipe_passed);
        end
        chk("t235_x", 32'(pipe_x), 32'd200);
        chk("t235_pulses", 32'(pulses), 32'd0);
        chk("t235_score", 32'(score), 32'd0);
        drv(1, 1, 0, 0);
        chk("t236_x", 32'(pipe_x), 32'd198);
        chk("t236_passed", 32'(pipe_passed), 32'd1);
        chk("t236_score", 32'(score), 32'd1);
        drv(1, 0, 0, 0);
        chk("pulse_width", 32'(pipe_passed), 32'd0);

        // Respawn
        for (int i = 0; i < 84; i++) drv(1, 1, 0, 0);
        chk("t320_x", 32'(pipe_x), 32'd30);
        exp_y = 100 + int'(m.lfsr[7:0]);
        drv(1, 1, 0, 0);
        chk("respawn_x", 32'(pipe_x), 32'd670);
        chk("respawn_y", 32'(pipe_y), 32'(exp_y));
        chk("respawn_passed", 32'(pipe_passed), 32'd0);

        // Collision wins over a same-cycle tick
        for (int i = 0; i < 135; i++) drv(1, 1, 0, 0);
        chk("pre_coll_x", 32'(pipe_x), 32'd400);
        drv(1, 1, 0, 1);
        chk("coll_x", 32'(pipe_x), 32'd400);
        chk("coll_over", 32'(game_over), 32'd1);
        for (int i = 0; i < 5; i++) begin
            drv(1, 1, 0, $urandom_range(0, 1));
            chk("dead_x", 32'(pipe_x), 32'd400);
            chk("dead_over", 32'(game_over), 32'd1);
        end

        // New game: play to score 3, die, then restart
        drv(1, 0, 1, 0);
        chk_idle("restart0");
        drv(1, 0, 1, 0);
        guard = 0;
        while (score != 8'd3 && guard < 5000) begin
            drv(1, $urandom_range(0, 3) != 0, 0, 0);
            guard++;
        end
        chk("reach3_score", 32'(score), 32'd3);
        drv(1, $urandom_range(0, 1), 0, 1);
        chk("dead3_over", 32'(game_over), 32'd1);
        chk("dead3_score", 32'(score), 32'd3);
        drv(1, 1, 1, 0);
        chk_idle("restart1");
        drv(1, 0, 1, 0);
        drv(1, 1, 0, 0);
        chk("rerun_x", 32'(pipe_x), 32'd668);
        chk("rerun_score", 32'(score), 32'd0);

        // Randomized play
        for (int i = 0; i < 3000; i++) begin
            drv($urandom_range(0, 199) != 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
        end

        // Reset on the cycle that would produce a pass and a collision
        drv(0, 0, 0, 0);
        drv(1, 0, 1, 0);
        for (int i = 0; i < 235; i++) drv(1, 1, 0, 0);
        chk("pre_rst_x", 32'(pipe_x), 32'd200);
        drv(0, 1, 0, 1);
        chk_idle("midrst");
        chk("midrst_passed", 32'(pipe_passed), 32'd0);

        // Saturation on the small-screen instance; main held in reset
        rst = 1'b0; ft = 1'b0; st = 1'b0; co = 1'b0;
        drv_s(0, 0, 0, 0);
        drv_s(1, 0, 1, 0);
        pulses = 0;
        guard  = 0;
        while (pulses < 258 && guard < 12000) begin
            drv_s(1, 1, 0, 0);
            if (s_passed) begin
                pulses++;
                if (pulses >= 255) chk("sat_score", 32'(s_score), 32'd255);
            end
            guard++;
        end
        chk("sat_pulses", 32'(pulses), 32'd258);
        chk("sat_final", 32'(s_score), 32'd255);
        drv_s(0, 1, 0, 1);
        chk("s_rst_x", 32'(s_x), 32'd68);
        chk("s_rst_score", 32'(s_score), 32'd0);
        chk("s_rst_passed", 32'(s_passed), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
